// File: rtl/ch1_sweep_freq.sv
// Channel 1 frequency sweep datapath: CPU-written frequency, shift shadow register,
// sweep adder/subtractor with sticky overflow, and the period counter.
module ch1_sweep_freq #(
    parameter int FREQ_W = 11
) (
    input  logic              ajer_2mhz,
    input  logic              apu_reset,
    input  logic [7:0]        d,
    input  logic              apu_wr,
    input  logic              ff13,
    input  logic              ff14,
    input  logic              ff10_d3,
    input  logic              ch1_restart,
    input  logic              ch1_ld_shift,
    input  logic              ch1_shift_clk,
    input  logic              ch1_freq_upd1,
    input  logic              ch1_freq_upd2,
    input  logic              ch1_freq_tick,
    output logic [FREQ_W-1:0] ch1_freq,
    output logic              ch1_period_tick,
    output logic              ch1_sweep_ovf
);

    localparam logic [FREQ_W-1:0] CNT_MAX = '1;

    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] shf;
    logic [FREQ_W-1:0] sum;
    logic [FREQ_W-1:0] cnt;
    logic [FREQ_W:0]   sum_next;

    // The extra top bit of the add result is the overflow carry; in subtract
    // mode it is only the borrow and is discarded.
    always_comb begin
        if (ff10_d3)
            sum_next = {1'b0, freq} - {1'b0, shf};
        else
            sum_next = {1'b0, freq} + {1'b0, shf};
    end

    // CPU writes are applied after the sweep load so the written byte wins.
    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset) begin
            freq <= '0;
        end else begin
            if (ch1_freq_upd2 && !ch1_sweep_ovf)
                freq <= sum;
            if (apu_wr && ff13)
                freq[7:0] <= d;
            if (apu_wr && ff14)
                freq[FREQ_W-1:8] <= d[FREQ_W-9:0];
        end
    end

    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset)
            shf <= '0;
        else if (ch1_ld_shift)
            shf <= freq;
        else if (ch1_shift_clk)
            shf <= {1'b0, shf[FREQ_W-1:1]};
    end

    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset)
            sum <= '0;
        else if (ch1_freq_upd1)
            sum <= sum_next[FREQ_W-1:0];
    end

    // Overflow set takes precedence over the restart clear.
    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset)
            ch1_sweep_ovf <= 1'b0;
        else if (ch1_freq_upd1 && !ff10_d3 && sum_next[FREQ_W])
            ch1_sweep_ovf <= 1'b1;
        else if (ch1_restart)
            ch1_sweep_ovf <= 1'b0;
    end

    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset) begin
            cnt             <= '0;
            ch1_period_tick <= 1'b0;
        end else begin
            ch1_period_tick <= 1'b0;
            if (ch1_restart) begin
                cnt <= freq;
            end else if (ch1_freq_tick) begin
                if (cnt == CNT_MAX) begin
                    cnt             <= freq;
                    ch1_period_tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign ch1_freq = freq;

endmodule

// File: tb/tb_ch1_sweep_freq.sv
// Scoreboard bench for ch1_sweep_freq: a behavioural model pushes expected outputs
// per driven cycle, a monitor pops and compares them after each rising edge.
module tb_ch1_sweep_freq;

    logic        ajer_2mhz = 1'b0;
    logic        apu_reset = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        apu_wr = 1'b0, ff13 = 1'b0, ff14 = 1'b0, ff10_d3 = 1'b0;
    logic        ch1_restart = 1'b0, ch1_ld_shift = 1'b0, ch1_shift_clk = 1'b0;
    logic        ch1_freq_upd1 = 1'b0, ch1_freq_upd2 = 1'b0, ch1_freq_tick = 1'b0;
    logic [10:0] ch1_freq;
    logic        ch1_period_tick;
    logic        ch1_sweep_ovf;

    typedef struct packed {
        logic [10:0] freq;
        logic        ovf;
        logic        tick;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [10:0] m_freq, m_shf, m_sum, m_cnt;
    logic        m_ovf, m_tick;

    ch1_sweep_freq #(.FREQ_W(11)) dut (
        .ajer_2mhz       (ajer_2mhz),
        .apu_reset       (apu_reset),
        .d               (d),
        .apu_wr          (apu_wr),
        .ff13            (ff13),
        .ff14            (ff14),
        .ff10_d3         (ff10_d3),
        .ch1_restart     (ch1_restart),
        .ch1_ld_shift    (ch1_ld_shift),
        .ch1_shift_clk   (ch1_shift_clk),
        .ch1_freq_upd1   (ch1_freq_upd1),
        .ch1_freq_upd2   (ch1_freq_upd2),
        .ch1_freq_tick   (ch1_freq_tick),
        .ch1_freq        (ch1_freq),
        .ch1_period_tick (ch1_period_tick),
        .ch1_sweep_ovf   (ch1_sweep_ovf)
    );

    always #5 ajer_2mhz = ~ajer_2mhz;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, advance the model, queue its outputs.
    task automatic applyStimulus(input logic rst, input logic wr, input logic f13, input logic f14,
                                 input logic [7:0] dd, input logic dir, input logic rs,
                                 input logic ld, input logic sh, input logic u1, input logic u2,
                                 input logic tk);
        logic [11:0] raw;
        logic [10:0] n_freq, n_shf, n_sum, n_cnt;
        logic        n_ovf, n_tick;
        @(negedge ajer_2mhz);
        apu_reset = rst; apu_wr = wr; ff13 = f13; ff14 = f14; d = dd; ff10_d3 = dir;
        ch1_restart = rs; ch1_ld_shift = ld; ch1_shift_clk = sh;
        ch1_freq_upd1 = u1; ch1_freq_upd2 = u2; ch1_freq_tick = tk;
        if (rst) begin
            n_freq = '0; n_shf = '0; n_sum = '0; n_cnt = '0; n_ovf = 1'b0; n_tick = 1'b0;
        end else begin
            raw    = dir ? ({1'b0, m_freq} - {1'b0, m_shf}) : ({1'b0, m_freq} + {1'b0, m_shf});
            n_sum  = u1 ? raw[10:0] : m_sum;
            n_ovf  = (u1 && !dir && raw[11]) ? 1'b1 : (rs ? 1'b0 : m_ovf);
            n_freq = (u2 && !m_ovf) ? m_sum : m_freq;
            if (wr && f13) n_freq[7:0] = dd;
            if (wr && f14) n_freq[10:8] = dd[2:0];
            n_shf  = ld ? m_freq : (sh ? (m_shf >> 1) : m_shf);
            n_tick = 1'b0;
            n_cnt  = m_cnt;
            if (rs) n_cnt = m_freq;
            else if (tk && m_cnt == 11'd2047) begin n_cnt = m_freq; n_tick = 1'b1; end
            else if (tk) n_cnt = m_cnt + 11'd1;
        end
        m_freq = n_freq; m_shf = n_shf; m_sum = n_sum; m_cnt = n_cnt; m_ovf = n_ovf; m_tick = n_tick;
        sb_q.push_back('{freq: n_freq, ovf: n_ovf, tick: n_tick});
        if (rst) begin
            #1;
            checkOutput("async_rst_freq", ch1_freq, 0);
            checkOutput("async_rst_ovf", ch1_sweep_ovf, 0);
            checkOutput("async_rst_tick", ch1_period_tick, 0);
        end
        @(posedge ajer_2mhz);
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cpuWrite(input logic f13, input logic f14, input logic [7:0] dd);
        applyStimulus(0, 1, f13, f14, dd, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic setFreq(input logic [10:0] f);
        cpuWrite(1, 0, f[7:0]);
        cpuWrite(0, 1, {5'b0, f[10:8]});
    endtask

    task automatic strobe(input logic dir, input logic rs, input logic ld, input logic sh,
                          input logic u1, input logic u2, input logic tk);
        applyStimulus(0, 0, 0, 0, 8'h00, dir, rs, ld, sh, u1, u2, tk);
    endtask

    always @(posedge ajer_2mhz) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("sb_freq", ch1_freq, e.freq);
            checkOutput("sb_ovf", ch1_sweep_ovf, e.ovf);
            checkOutput("sb_tick", ch1_period_tick, e.tick);
        end
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_freq", ch1_freq, 0);
        idle();

        cpuWrite(1, 0, 8'h34);
        cpuWrite(0, 1, 8'h05);
        checkOutput("write_534", ch1_freq, 11'h534);
        cpuWrite(0, 1, 8'hFF);
        checkOutput("write_734", ch1_freq, 11'h734);

        setFreq(11'h400);
        strobe(0, 0, 1, 0, 0, 0, 0);
        strobe(0, 0, 0, 1, 0, 0, 0);
        strobe(0, 0, 0, 1, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, 0, 0);
        strobe(0, 0, 0, 0, 0, 1, 0);
        checkOutput("add_500", ch1_freq, 11'h500);
        checkOutput("add_ovf0", ch1_sweep_ovf, 0);

        setFreq(11'h700);
        strobe(0, 0, 1, 0, 0, 0, 0);
        strobe(0, 0, 0, 1, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, 0, 0);
        checkOutput("ovf_set", ch1_sweep_ovf, 1);
        strobe(0, 0, 0, 0, 0, 1, 0);
        checkOutput("ovf_hold_freq", ch1_freq, 11'h700);
        strobe(0, 1, 0, 0, 0, 0, 0);
        checkOutput("ovf_restart_clr", ch1_sweep_ovf, 0);

        setFreq(11'h100);
        strobe(1, 0, 1, 0, 0, 0, 0);
        strobe(1, 0, 0, 0, 1, 0, 0);
        strobe(1, 0, 0, 0, 0, 1, 0);
        checkOutput("sub_zero", ch1_freq, 0);
        checkOutput("sub_no_ovf", ch1_sweep_ovf, 0);

        setFreq(11'd2044);
        strobe(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            strobe(0, 0, 0, 0, 0, 0, 1);
            checkOutput($sformatf("period_tick_%0d", i), ch1_period_tick, (i == 4 || i == 8));
        end
        idle();
        checkOutput("period_tick_drop", ch1_period_tick, 0);

        // Load beats shift; upd1+upd2 together use the previous sum.
        setFreq(11'h010);
        strobe(0, 0, 1, 1, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, 0, 0);
        strobe(0, 0, 0, 0, 0, 1, 0);
        checkOutput("ld_over_shift", ch1_freq, 11'h020);
        setFreq(11'h005);
        strobe(0, 0, 1, 0, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, 1, 0);
        checkOutput("upd12_old_sum", ch1_freq, 11'h020);
        strobe(0, 0, 0, 0, 0, 1, 0);
        checkOutput("upd2_new_sum", ch1_freq, 11'h00A);

        setFreq(11'h7FF);
        strobe(0, 0, 1, 0, 0, 0, 0);
        strobe(0, 1, 0, 0, 1, 0, 0);
        checkOutput("ovf_set_beats_restart", ch1_sweep_ovf, 1);
        strobe(0, 1, 0, 0, 0, 0, 0);

        setFreq(11'h123);
        strobe(0, 0, 1, 0, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 8'h99, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("write_beats_upd2", ch1_freq, 11'h299);

        setFreq(11'h7FF);
        strobe(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            strobe(0, 0, 0, 0, 0, 0, 1);
            checkOutput("tick_every_2047", ch1_period_tick, 1);
        end
        strobe(0, 1, 0, 0, 0, 0, 1);
        checkOutput("restart_over_tick", ch1_period_tick, 0);

        setFreq(11'h200);
        strobe(0, 0, 1, 0, 0, 0, 0);
        strobe(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        idle();
        strobe(0, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_abort_freq", ch1_freq, 0);
        checkOutput("rst_abort_ovf", ch1_sweep_ovf, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(3) == 0), 1'($urandom),
                          1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(15) == 0),
                          ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                          ($urandom_range(3) == 0), ($urandom_range(3) == 0), 1'($urandom));
        end

        idle();
        @(posedge ajer_2mhz);
        #3;
        checkOutput("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
